mantissa_alu_seq: RTL
=====================

Name: mantissa_alu_seq

Overview:
- Parametrised, clocked sign-magnitude mantissa ALU for the floating-point datapath.
- Supersedes the single-edge add-only unit with:
  - explicit SUB,
  - a multi-cycle shift-add multiplier,
  - a start/busy/done handshake.
- Sits between operand alignment and normalisation/rounding; the FPU control FSM drives start and waits for done.

Parameters:
- WIDTH, 27, magnitude width of each operand (hidden bit + fraction + guard/round bits).
- CNT_W, $clog2(WIDTH+1), width of the multiplier iteration counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- operation  input  2  00 ADD, 01 SUB, 10 MUL, 11 ADD (alias).
- input_a  input  WIDTH  magnitude A.
- sign_a  input  1  sign A.
- input_b  input  WIDTH  magnitude B.
- sign_b  input  1  sign B.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result valid.
- result  output  2*WIDTH  magnitude. ADD/SUB use the low WIDTH+1 bits, upper bits zero.
- sign_result  output  1  sign of result.
- carry  output  1  ADD/SUB magnitude overflow, equal to result[WIDTH]; 0 for MUL.

Behaviour:
- Reset (async): state=IDLE; busy, done, carry, sign_result = 0; result = 0; internal counter and registers = 0.
- Operand capture: operands, signs and operation are registered when start=1 in IDLE. Inputs may change afterwards without effect.
- FSM states: IDLE, ADDSUB, MUL, DONE.
  - IDLE: if start, go to ADDSUB (op 00/01/11) or MUL (op 10).
  - ADDSUB: compute in one cycle, then go to DONE.
  - MUL: iterate, then go to DONE when the counter reaches WIDTH.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency, counted as edges from the accepting edge to the edge where done rises:
  - ADD/SUB: 2.
  - MUL: WIDTH+2.
- Effective sign of B: sb = sign_b ^ (operation==01).
- ADD/SUB arithmetic, in WIDTH+1 bits:
  - sign_a == sb: result = A+B, sign_result = sign_a, carry = result[WIDTH].
  - sign_a != sb and A > B: result = A-B, sign_result = sign_a, carry = 0.
  - sign_a != sb and A < B: result = B-A, sign_result = sb, carry = 0.
  - sign_a != sb and A == B: result = 0, sign_result = 0 (+0), carry = 0.
  - The result is never a two's-complement value; the magnitude is always non-negative.
- MUL, radix-2 shift-add:
  - Accumulator is 2*WIDTH bits.
  - Each MUL cycle: if the current multiplier LSB=1, add the shifted multiplicand; then shift; counter+1.
  - result = A*B exact, 2*WIDTH bits, no truncation.
  - sign_result = sign_a ^ sign_b, also for zero products (IEEE signed zero).
  - carry = 0.
- Output holding: result, sign_result and carry update only on the DONE-entry edge and hold until the next DONE.
- busy=1 in ADDSUB and MUL; busy=0 in DONE and IDLE.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE, giving back-to-back throughput of one op per latency+1 cycles.
- Reset mid-operation: abort immediately to the reset values; no done pulse.
- Boundaries:
  - A = B = 2^WIDTH-1 with ADD: carry=1, result[WIDTH:0] = 2^(WIDTH+1)-2.
  - MUL of two all-ones operands: full product with no overflow.
  - Operand 0 in MUL: product 0; latency unchanged unless early termination is enabled.

Optional Feature:
- Macro: MANTISSA_ALU_EARLY_TERM_EN.
- Defined: in MUL, when the remaining unshifted multiplier bits are all zero, go to DONE on the next edge.
  - Latency = 2 + (index of the highest set bit of B) + 1.
  - B=0 gives latency 2.
  - Results are identical to the non-early-termination case.
- Undefined: MUL latency is fixed at WIDTH+2 for all operands. Bench latency checks are exact.

Test Plan:
- Reset mid-MUL: assert rst 5 cycles after a MUL start -> busy=0, done never pulses, result=0, sign_result=0, carry=0 in the same cycle as rst.
- ADD with WIDTH=27, A=0x4000000, B=0x4000000, both signs 0 -> done after 2 edges, result=0x8000000, carry=1, sign=0.
- SUB with A=0x0000010, B=0x0000030, sign_a=0, sign_b=0 -> result=0x20, sign_result=1, carry=0. Same with A=B -> result=0, sign_result=0.
- MUL with A=0x7FFFFFF, B=0x0000003, sign_a=1, sign_b=0 -> done after 29 edges (macro undefined), result=0x17FFFFFD, sign_result=1, carry=0.
- Handshake: start pulsed again while busy, with different operands -> ignored; first result unchanged; exactly one done pulse; with start held high, the second op is accepted the cycle after done.
- With MANTISSA_ALU_EARLY_TERM_EN: MUL with B=0x1 -> done after 3 edges, result=A. MUL with B=0 -> done after 2 edges, result=0, sign=sign_a^sign_b.

Source files
------------

// File: rtl/mantissa_alu_seq.sv
// Clocked sign-magnitude mantissa ALU: one-cycle ADD/SUB, radix-2 shift-add MUL, start/busy/done handshake.
// Optional early MUL termination when the remaining multiplier bits are zero: define MANTISSA_ALU_EARLY_TERM_EN.
module mantissa_alu_seq #(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         operation,
    input  logic [WIDTH-1:0]   input_a,
    input  logic               sign_a,
    input  logic [WIDTH-1:0]   input_b,
    input  logic               sign_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               sign_result,
    output logic               carry
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDSUB = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;        // also the MUL multiplier, shifted right each iteration
    logic               sa_q;
    logic               sb_q;       // effective sign of B (SUB already folded in)
    logic               smul_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0] ext_a, ext_b;
    logic [WIDTH:0] as_mag;
    logic           as_sign;
    logic           as_carry;
    logic           mul_stop;

    assign ext_a = {1'b0, a_q};
    assign ext_b = {1'b0, b_q};

    // Magnitude add/subtract; the larger magnitude always minuend so the result stays non-negative.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        as_mag   = '0;
        as_sign  = 1'b0;
        as_carry = 1'b0;
        if (sa_q == sb_q) begin
            as_mag   = ext_a + ext_b;
            as_sign  = sa_q;
            as_carry = as_mag[WIDTH];
        end else if (a_q > b_q) begin
            as_mag  = ext_a - ext_b;
            as_sign = sa_q;
        end else if (a_q < b_q) begin
            as_mag  = ext_b - ext_a;
            as_sign = sb_q;
        end
    end

`ifdef MANTISSA_ALU_EARLY_TERM_EN
    assign mul_stop = (cnt_q == CNT_W'(WIDTH)) || (b_q == '0);
`else
    assign mul_stop = (cnt_q == CNT_W'(WIDTH));
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (operation == 2'b10) ? MUL : ADDSUB;
            ADDSUB:  state_next = DONE;
            MUL:     if (mul_stop) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign busy = (state == ADDSUB) || (state == MUL);
    assign done = (state == DONE);

    // NOTE: operand and output registers are few and small, so all of them get the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            smul_q      <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result      <= '0;
            sign_result <= 1'b0;
            carry       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= input_a;
                        b_q     <= input_b;
                        sa_q    <= sign_a;
                        sb_q    <= sign_b ^ (operation == 2'b01);
                        smul_q  <= sign_a ^ sign_b;
                        mcand_q <= {{WIDTH{1'b0}}, input_a};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ADDSUB: begin
                    result      <= {{(WIDTH-1){1'b0}}, as_mag};
                    sign_result <= as_sign;
                    carry       <= as_carry;
                end
                MUL: begin
                    if (mul_stop) begin
                        result      <= acc_q;
                        sign_result <= smul_q;
                        carry       <= 1'b0;
                    end else begin
                        if (b_q[0]) acc_q <= acc_q + mcand_q;
                        mcand_q <= mcand_q << 1;
                        b_q     <= b_q >> 1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
